// File: rtl/ir_cmd_ctrl_pkg.sv
// Shared definitions for the IR command controller: SIRC field widths,
// event and state encodings, width sizing and frame field unpacking.
package ir_cmd_ctrl_pkg;

  localparam int CMD_W   = 7;
  localparam int ADDR_W  = 5;
  localparam int FRAME_W = 12;
  localparam int CNT_W   = 4;   // holds REPEAT_MIN / HOLD_FRAMES (max 15)

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_REPEAT  = 2'b01,
    EVT_RELEASE = 2'b10
  } evt_type_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_QUALIFY = 2'b01,
    S_HELD    = 2'b10
  } ctrl_state_e;

  // Bits needed to represent values 0..value-1.
  function automatic int clog2(input longint unsigned value);
    int r;
    for (r = 0; (longint'(1) << r) < value; r++) begin
    end
    return r;
  endfunction

  // Command bits arrive LSB first, so frame_data[11] is cmd[0].
  function automatic logic [CMD_W-1:0] unpack_cmd(input logic [FRAME_W-1:0] f);
    logic [CMD_W-1:0] c;
    for (int i = 0; i < CMD_W; i++) c[i] = f[FRAME_W-1-i];
    return c;
  endfunction

  // Address bits follow the command, also LSB first: frame_data[4] is addr[0].
  function automatic logic [ADDR_W-1:0] unpack_addr(input logic [FRAME_W-1:0] f);
    logic [ADDR_W-1:0] a;
    for (int j = 0; j < ADDR_W; j++) a[j] = f[ADDR_W-1-j];
    return a;
  endfunction

endpackage

// File: rtl/ir_gap_timer.sv
// Saturating idle timer: cleared by each accepted frame, flags timeout once
// it has counted GAP_CYCLES cycles without a clear.
module ir_gap_timer
  import ir_cmd_ctrl_pkg::*;
#(
  parameter int GAP_CYCLES = 3000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic timeout
);

  localparam int TW = clog2(longint'(GAP_CYCLES) + 1);
  localparam logic [TW-1:0] GAP_MAX = TW'(GAP_CYCLES);

  logic [TW-1:0] cnt_reg;

  // Count up until saturation; any accepted frame restarts the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (cnt_reg != GAP_MAX) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign timeout = (cnt_reg == GAP_MAX);

endmodule

// File: rtl/ir_cmd_ctrl.sv
// IR command controller: qualifies repeating SIRC frames into press /
// auto-repeat / release events with a single-entry valid/ready output.
// Optional address filtering is compiled in with the IR_ADDR_FILTER_EN macro.
module ir_cmd_ctrl
  import ir_cmd_ctrl_pkg::*;
#(
  parameter int               REPEAT_MIN  = 3,
  parameter int               HOLD_FRAMES = 4,
  parameter int               GAP_CYCLES  = 3000000,
  parameter logic [ADDR_W-1:0] DEVICE_ADDR = 5'h01
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_rdy,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [1:0]         evt_type,
  output logic [CMD_W-1:0]   evt_cmd,
  output logic [ADDR_W-1:0]  evt_addr,
  output logic [7:0]         drop_cnt
);

`ifdef IR_ADDR_FILTER_EN
  localparam bit ADDR_FILTER = 1'b1;
`else
  localparam bit ADDR_FILTER = 1'b0;
`endif

  localparam logic [CNT_W-1:0] REPEAT_MIN_C  = CNT_W'(REPEAT_MIN);
  localparam logic [CNT_W-1:0] HOLD_FRAMES_C = CNT_W'(HOLD_FRAMES);

  logic               rdy_prev_reg;
  logic               frame_edge, addr_ok, accept, timeout;
  ctrl_state_e        state_reg, state_next;
  logic [FRAME_W-1:0] code_reg, code_next;
  logic [CNT_W-1:0]   match_reg, match_next, hold_reg, hold_next;
  logic [CNT_W-1:0]   match_inc, hold_inc;
  logic               same_code, qualify_hit, hold_hit;
  logic               emit;
  evt_type_e          emit_type;

  // Previous ready level resets high so a level already up is not a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_prev_reg <= 1'b1;
    else        rdy_prev_reg <= frame_rdy;
  end

  assign frame_edge  = frame_rdy && !rdy_prev_reg;
  assign addr_ok     = !ADDR_FILTER || (unpack_addr(frame_data) == DEVICE_ADDR);
  assign accept      = frame_edge && addr_ok;
  assign same_code   = (frame_data == code_reg);
  assign match_inc   = match_reg + 1'b1;
  assign hold_inc    = hold_reg + 1'b1;
  assign qualify_hit = same_code && (match_inc == REPEAT_MIN_C);
  assign hold_hit    = same_code && (hold_inc == HOLD_FRAMES_C);

  ir_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .timeout(timeout)
  );

  // State register with latched code and qualification counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      code_reg  <= '0;
      match_reg <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      code_reg  <= code_next;
      match_reg <= match_next;
      hold_reg  <= hold_next;
    end
  end

  // Next-state logic; an accepted frame takes priority over a timeout.
  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    match_next = match_reg;
    hold_next  = hold_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          code_next  = frame_data;
          match_next = CNT_W'(1);
          state_next = S_QUALIFY;
        end
      end
      S_QUALIFY: begin
        if (accept) begin
          if (qualify_hit) begin
            hold_next  = '0;
            state_next = S_HELD;
          end else if (same_code) begin
            match_next = match_inc;
          end else begin
            code_next  = frame_data;
            match_next = CNT_W'(1);
          end
        end else if (timeout) begin
          match_next = '0;
          state_next = S_IDLE;
        end
      end
      S_HELD: begin
        if (accept) begin
          if (hold_hit) begin
            hold_next = '0;
          end else if (same_code) begin
            hold_next = hold_inc;
          end else begin
            code_next  = frame_data;
            match_next = CNT_W'(1);
            hold_next  = '0;
            state_next = S_QUALIFY;
          end
        end else if (timeout) begin
          hold_next  = '0;
          match_next = '0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Event generation; every event carries the currently latched code.
  always_comb begin
    emit      = 1'b0;
    emit_type = EVT_PRESS;
    case (state_reg)
      S_QUALIFY: begin
        if (accept && qualify_hit) emit = 1'b1;
      end
      S_HELD: begin
        if (accept) begin
          if (hold_hit) begin
            emit      = 1'b1;
            emit_type = EVT_REPEAT;
          end else if (!same_code) begin
            emit      = 1'b1;
            emit_type = EVT_RELEASE;
          end
        end else if (timeout) begin
          emit      = 1'b1;
          emit_type = EVT_RELEASE;
        end
      end
      default: ;
    endcase
  end

  // Single-entry output holding register; events arriving while it is
  // blocked are counted as drops instead of overwriting the held event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_type  <= 2'b00;
      evt_cmd   <= '0;
      evt_addr  <= '0;
      drop_cnt  <= '0;
    end else if (emit) begin
      if (!evt_valid || evt_ready) begin
        evt_valid <= 1'b1;
        evt_type  <= emit_type;
        evt_cmd   <= unpack_cmd(code_reg);
        evt_addr  <= unpack_addr(code_reg);
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule
